// File: rtl/osc_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter.
package osc_meter_pkg;

  // FSM encodings
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_t;

  // Default prescaler width and the number of oscillator cycles one counted event stands for
  localparam int unsigned DEF_DIV_LOG2  = 4;
  localparam int unsigned OSC_PER_EVENT = 1 << (DEF_DIV_LOG2 - 1);

  // Oscillator cycles per counted event for an arbitrary prescaler width
  function automatic int unsigned osc_cycles_per_event(input int unsigned div_log2);
    return 1 << (div_log2 - 1);
  endfunction

endpackage

// File: rtl/osc_prescaler.sv
// Oscillator-domain divider. Kept on its own so the osc_i clock net and
// its single flop bank can be constrained separately; osc_i feeds only
// this counter and must not be buffered onto a clock tree anywhere else.
import osc_meter_pkg::*;

module osc_prescaler #(
  parameter int unsigned DIV_LOG2 = DEF_DIV_LOG2
) (
  input  logic osc_i,
  input  logic rst_ni,
  output logic msb_o
);

  logic [DIV_LOG2-1:0] div_q;

  // Free-running divider; the MSB toggles once every 2**(DIV_LOG2-1) osc cycles
  always_ff @(posedge osc_i or negedge rst_ni) begin
    if (!rst_ni) div_q <= '0;
    else         div_q <= div_q + 1'b1;
  end

  assign msb_o = div_q[DIV_LOG2-1];

endmodule

// File: rtl/osc_freq_meter.sv
// Oscillator frequency meter: enables the ring oscillator, lets it settle,
// then counts synchronised prescaler toggles over a programmable window.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | oscillator off, waiting for start_i
//   ST_WARMUP  | oscillator on, settling; event counter held at zero
//   ST_MEASURE | counting events for the latched number of gate cycles
import osc_meter_pkg::*;

module osc_freq_meter #(
  parameter int unsigned DIV_LOG2      = 4,
  parameter int unsigned GATE_W        = 16,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned WARMUP_CYCLES = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [GATE_W-1:0] gate_cycles_i,
  input  logic              osc_i,
  output logic              osc_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  localparam int unsigned WU_W  = $clog2(WARMUP_CYCLES + 1);
  localparam int unsigned TMR_W = (GATE_W > WU_W) ? GATE_W : WU_W;
  // The accept cycle plus a terminal-count-at-zero timer gives WARMUP_CYCLES
  // full settle cycles after osc_en_o is first seen high downstream.
  localparam logic [TMR_W-1:0] WU_LOAD = TMR_W'(WARMUP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meter_state_t      state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  acc_q, acc_d, acc_nx;
  logic              sat_q, sat_d, sat_nx;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic              div_msb;
  logic [2:0]        sync_q;
  logic              evt;

  osc_prescaler #(.DIV_LOG2(DIV_LOG2)) u_prescaler (
    .osc_i  (osc_i),
    .rst_ni (wb_rst_ni),
    .msb_o  (div_msb)
  );

  // Two-flop synchroniser for the divider MSB plus one delayed copy for edge detect
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) sync_q <= '0;
    else            sync_q <= {sync_q[1:0], div_msb};
  end

  assign evt = sync_q[2] ^ sync_q[1];

  // Next-state, timer and result logic; abort always beats completion
  always_comb begin
    acc_nx  = acc_q;
    sat_nx  = sat_q;
    if (evt) begin
      if (acc_q == CNT_MAX) sat_nx = 1'b1;
      else                  acc_nx = acc_q + CNT_W'(1);
    end

    state_d = state_q;
    tmr_d   = tmr_q;
    gate_d  = gate_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    en_d    = en_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          gate_d  = gate_cycles_i;
          tmr_d   = WU_LOAD;
          acc_d   = '0;
          sat_d   = 1'b0;
          en_d    = 1'b1;
          state_d = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        acc_d = '0;
        sat_d = 1'b0;
        if (abort_i) begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          if (gate_q == '0) begin
            count_d = '0;
            ovf_d   = 1'b0;
            done_d  = 1'b1;
            en_d    = 1'b0;
            state_d = ST_IDLE;
          end else begin
            tmr_d   = TMR_W'(gate_q) - TMR_W'(1);
            state_d = ST_MEASURE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        acc_d = acc_nx;
        sat_d = sat_nx;
        if (abort_i) begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          count_d = acc_nx;
          ovf_d   = sat_nx;
          done_d  = 1'b1;
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      gate_q  <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      gate_q  <= gate_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign osc_en_o   = en_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter. Two instances share the control
// inputs: a 20-bit counter and an 8-bit counter that must saturate.
module tb_osc_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] gate = '0;
  logic        osc_a = 1'b0;
  logic        osc_b = 1'b0;
  logic        osc_kill = 1'b0;

  logic        en_a, busy_a, done_a, ovf_a;
  logic [19:0] cnt_a;
  logic        en_b, busy_b, done_b, ovf_b;
  logic [7:0]  cnt_b;
  logic        run_a, run_b;

  int checks = 0;
  int errors = 0;

  osc_freq_meter #(.DIV_LOG2(4), .GATE_W(16), .CNT_W(20), .WARMUP_CYCLES(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .gate_cycles_i(gate), .osc_i(osc_a), .osc_en_o(en_a), .busy_o(busy_a),
    .done_o(done_a), .count_o(cnt_a), .overflow_o(ovf_a)
  );

  osc_freq_meter #(.DIV_LOG2(4), .GATE_W(16), .CNT_W(8), .WARMUP_CYCLES(16)) dut8 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .gate_cycles_i(gate), .osc_i(osc_b), .osc_en_o(en_b), .busy_o(busy_b),
    .done_o(done_b), .count_o(cnt_b), .overflow_o(ovf_b)
  );

  // 10 ns system clock (1 ps time unit)
  always #5000 clk = ~clk;

  assign run_a = en_a & ~osc_kill;
  assign run_b = en_b & ~osc_kill;

  // 3 ns oscillators; the 0.7 ns start offset keeps osc edges off clk edges
  always begin
    @(posedge run_a);
    #700;
    while (run_a) begin
      osc_a = ~osc_a;
      #1500;
    end
  end

  always begin
    @(posedge run_b);
    #700;
    while (run_b) begin
      osc_b = ~osc_b;
      #1500;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Present start for one edge; returns at the negedge after the accept edge
  task automatic start_meas(input logic [15:0] g);
    @(negedge clk);
    gate  = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges until done_o is seen on the 20-bit instance
  task automatic wait_done(input int max, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < max) begin
      @(negedge clk);
      cyc++;
      if (done_a) seen = 1'b1;
    end
  endtask

  int cyc;
  bit seen;
  bit any_done;

  initial begin
    // Reset state
    #12000;
    chk("rst_en",    en_a,   0);
    chk("rst_busy",  busy_a, 0);
    chk("rst_done",  done_a, 0);
    chk("rst_count", cnt_a,  0);
    chk("rst_ovf",   ovf_a,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: G=1000, 3 ns oscillator -> 416..417 events; 8-bit copy saturates
    start_meas(16'd1000);
    chk("t1_busy", busy_a, 1);
    chk("t1_en",   en_a,   1);
    wait_done(1200, cyc, seen);
    chk("t1_done_seen", seen, 1);
    chk("t1_latency", cyc, 1017);
    chk("t1_count_rng", (cnt_a >= 20'd416 && cnt_a <= 20'd417), 1);
    chk("t1_ovf", ovf_a, 0);
    chk("t1_en_off", en_a, 0);
    chk("t1_busy_off", busy_a, 0);
    chk("t4_done8", done_b, 1);
    chk("t4_count8", cnt_b, 255);
    chk("t4_ovf8", ovf_b, 1);
    @(negedge clk);
    chk("t1_done_pulse", done_a, 0);

    // 3: abort on MEASURE cycle 500
    start_meas(16'd1000);
    repeat (516) @(negedge clk);
    chk("t3_busy_pre", busy_a, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_en_off", en_a, 0);
    chk("t3_busy_off", busy_a, 0);
    chk("t3_done", done_a, 0);
    any_done = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (done_a) any_done = 1'b1;
    end
    chk("t3_no_done", any_done, 0);
    chk("t3_count_kept", (cnt_a >= 20'd416 && cnt_a <= 20'd417), 1);
    chk("t3_count8_kept", cnt_b, 255);

    // 2: G=0 -> done 17 cycles after accept, count 0
    start_meas(16'd0);
    wait_done(100, cyc, seen);
    chk("t2_done_seen", seen, 1);
    chk("t2_latency", cyc, 17);
    chk("t2_count", cnt_a, 0);
    chk("t2_ovf", ovf_a, 0);
    chk("t2_ovf8", ovf_b, 0);

    // 6: oscillator stopped, extra start while busy ignored
    osc_kill = 1'b1;
    start_meas(16'd50);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 10;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done_a) seen = 1'b1;
    end
    chk("t6_done_seen", seen, 1);
    chk("t6_latency", cyc, 67);
    chk("t6_count", cnt_a, 0);
    chk("t6_count8", cnt_b, 0);
    @(negedge clk);
    chk("t6_idle", busy_a, 0);

    // start held high: next measurement accepted the edge after done
    @(negedge clk);
    gate  = 16'd0;
    start = 1'b1;
    @(negedge clk);
    wait_done(100, cyc, seen);
    chk("hold_latency", cyc, 17);
    @(negedge clk);
    chk("hold_rearm", busy_a, 1);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("hold_abort", busy_a, 0);
    osc_kill = 1'b0;

    // 5: async reset mid-MEASURE, then a clean repeat of test 1
    start_meas(16'd1000);
    repeat (317) @(negedge clk);
    #1000;
    rst_n = 1'b0;
    #100;
    chk("t5_en",    en_a,   0);
    chk("t5_busy",  busy_a, 0);
    chk("t5_done",  done_a, 0);
    chk("t5_count", cnt_a,  0);
    chk("t5_ovf8",  ovf_b,  0);
    @(negedge clk);
    rst_n = 1'b1;
    start_meas(16'd1000);
    wait_done(1200, cyc, seen);
    chk("t5_latency", cyc, 1017);
    chk("t5_count_rng", (cnt_a >= 20'd416 && cnt_a <= 20'd417), 1);
    chk("t5_ovf", ovf_a, 0);
    chk("t5_count8", cnt_b, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
